// File: rtl/axi_sram_responder.sv
// axi_sram_responder: single-beat AXI4 slave backed by a word-addressed,
// byte-strobed SRAM. AW and W are captured in independent holding registers
// and committed together once no write response is outstanding. Each read
// is answered from the SRAM one cycle after its AR handshake.
// Optional macro AXI_SRAM_RESP_ERR_EN: addresses >= MEMSIZE return SLVERR,
// do not write the SRAM and read back zero. Without it, addresses wrap
// modulo MEMSIZE and every response is OKAY.
module axi_sram_responder #(
  parameter int AW      = 13,
  parameter int MEMSIZE = 8192,
  parameter     MEMFILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic [1:0]    o_bresp,
  output logic          o_bvalid,
  input  logic          i_bready,
  input  logic [AW-1:0] i_araddr,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic          o_rvalid,
  input  logic          i_rready
);

  localparam int IW    = $clog2(MEMSIZE);
  localparam int DEPTH = MEMSIZE / 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [0:DEPTH-1];

  // Write holding registers
  logic          aw_hold;
  logic [IW-3:0] aw_idx;
  logic          aw_err;
  logic          w_hold;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;

  logic          aw_oor;
  logic          ar_oor;
  logic          aw_fire;
  logic          w_fire;
  logic          ar_fire;
  logic          commit;
  logic [IW-3:0] ar_idx;

  // All address bits feed the range check in the error build; in the wrap
  // build the high and byte-lane bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_awaddr, i_araddr};

`ifdef AXI_SRAM_RESP_ERR_EN
  assign aw_oor = (64'(i_awaddr) >= 64'(MEMSIZE));
  assign ar_oor = (64'(i_araddr) >= 64'(MEMSIZE));
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign o_awready = !rst && !aw_hold;
  assign o_wready  = !rst && !w_hold;
  assign o_arready = !rst && !o_rvalid;

  assign aw_fire = i_awvalid && o_awready;
  assign w_fire  = i_wvalid  && o_wready;
  assign ar_fire = i_arvalid && o_arready;
  assign commit  = !rst && aw_hold && w_hold && !o_bvalid;
  assign ar_idx  = i_araddr[IW-1:2];

  // AW/W capture, commit and B response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_hold  <= 1'b0;
      aw_idx   <= '0;
      aw_err   <= 1'b0;
      w_hold   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      o_bvalid <= 1'b0;
      o_bresp  <= RESP_OKAY;
    end else begin
      // commit needs both holds set, handshakes need them clear: never together
      if (commit) begin
        aw_hold  <= 1'b0;
        w_hold   <= 1'b0;
        o_bvalid <= 1'b1;
        o_bresp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end else if (o_bvalid && i_bready) begin
        o_bvalid <= 1'b0;
      end
      if (aw_fire) begin
        aw_hold <= 1'b1;
        aw_idx  <= i_awaddr[IW-1:2];
        aw_err  <= aw_oor;
      end
      if (w_fire) begin
        w_hold <= 1'b1;
        w_data <= i_wdata;
        w_strb <= i_wstrb;
      end
    end
  end

  // SRAM byte-strobed write on commit; contents survive reset
  always_ff @(posedge clk) begin
    if (commit && !aw_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read response: sample SRAM at AR handshake (old data on same-edge write)
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
      o_rresp  <= RESP_OKAY;
      o_rdata  <= '0;
    end else if (ar_fire) begin
      o_rvalid <= 1'b1;
      o_rlast  <= 1'b1;
      o_rresp  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      o_rdata  <= ar_oor ? 32'h0 : mem[ar_idx];
    end else if (o_rvalid && i_rready) begin
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
    end
  end

endmodule
